// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, instruction
// classes, datapath mux codes, ALU operation codes and opcode/func values.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_EXC    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_RALU, C_IALU, C_LOAD, C_STORE, C_BEQ, C_BNE, C_J, C_JAL, C_JR
  } cls_t;

  localparam logic [1:0] PCSEL_PC4 = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;
  localparam logic [1:0] PCSEL_RS  = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [4:0] ALUOp_NOP  = 5'd0;
  localparam logic [4:0] ALUOp_ADDU = 5'd1;
  localparam logic [4:0] ALUOp_ADD  = 5'd2;
  localparam logic [4:0] ALUOp_SUBU = 5'd3;
  localparam logic [4:0] ALUOp_SUB  = 5'd4;
  localparam logic [4:0] ALUOp_AND  = 5'd5;
  localparam logic [4:0] ALUOp_OR   = 5'd6;
  localparam logic [4:0] ALUOp_SLT  = 5'd7;
  localparam logic [4:0] ALUOp_SLL  = 5'd8;
  localparam logic [4:0] ALUOp_SRL  = 5'd9;
  localparam logic [4:0] ALUOp_SRA  = 5'd10;
  localparam logic [4:0] ALUOp_LUI  = 5'd11;

  function automatic logic is_mem_cls(input cls_t c);
    return (c == C_LOAD) || (c == C_STORE);
  endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational opcode/func decode into an instruction class plus the ALU-side
// controls (ALUCtrl/ALUSrc/ExtOp/ByteEn); no state, zero latency.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5
) (
  input  logic [5:0]         i_opcode,
  input  logic [5:0]         i_func,
  output cls_t               o_cls,
  output logic [ALUOP_W-1:0] o_aluctrl,
  output logic               o_alusrc,
  output logic               o_extop,
  output logic               o_byteen
);

  always_comb begin
    o_cls     = C_ILL;
    o_aluctrl = '0;
    o_alusrc  = 1'b0;
    o_extop   = 1'b0;
    o_byteen  = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_func)
          FN_ADDU: begin o_cls = C_RALU; o_aluctrl = ALUOP_W'(ALUOp_ADDU); end
          FN_ADD:  begin o_cls = C_RALU; o_aluctrl = ALUOP_W'(ALUOp_ADD);  end
          FN_SUBU: begin o_cls = C_RALU; o_aluctrl = ALUOP_W'(ALUOp_SUBU); end
          FN_SUB:  begin o_cls = C_RALU; o_aluctrl = ALUOP_W'(ALUOp_SUB);  end
          FN_AND:  begin o_cls = C_RALU; o_aluctrl = ALUOP_W'(ALUOp_AND);  end
          FN_OR:   begin o_cls = C_RALU; o_aluctrl = ALUOP_W'(ALUOp_OR);   end
          FN_SLT:  begin o_cls = C_RALU; o_aluctrl = ALUOP_W'(ALUOp_SLT);  end
          // Shifts take shamt through the immediate leg of the ALU B mux.
          FN_SLL:  begin o_cls = C_RALU; o_aluctrl = ALUOP_W'(ALUOp_SLL); o_alusrc = 1'b1; end
          FN_SRL:  begin o_cls = C_RALU; o_aluctrl = ALUOP_W'(ALUOp_SRL); o_alusrc = 1'b1; end
          FN_SRA:  begin o_cls = C_RALU; o_aluctrl = ALUOP_W'(ALUOp_SRA); o_alusrc = 1'b1; end
          FN_JR:   o_cls = C_JR;
          default: o_cls = C_ILL;
        endcase
      end
      OP_ADDI: begin o_cls = C_IALU; o_aluctrl = ALUOP_W'(ALUOp_ADD); o_alusrc = 1'b1; o_extop = 1'b1; end
      OP_SLTI: begin o_cls = C_IALU; o_aluctrl = ALUOP_W'(ALUOp_SLT); o_alusrc = 1'b1; o_extop = 1'b1; end
      OP_ORI:  begin o_cls = C_IALU; o_aluctrl = ALUOP_W'(ALUOp_OR);  o_alusrc = 1'b1; end
      OP_LUI:  begin o_cls = C_IALU; o_aluctrl = ALUOP_W'(ALUOp_LUI); o_alusrc = 1'b1; end
      OP_LB: begin
        o_cls = C_LOAD; o_aluctrl = ALUOP_W'(ALUOp_ADDU); o_alusrc = 1'b1; o_extop = 1'b1; o_byteen = 1'b1;
      end
      OP_LW: begin o_cls = C_LOAD; o_aluctrl = ALUOP_W'(ALUOp_ADDU); o_alusrc = 1'b1; o_extop = 1'b1; end
      OP_SB: begin
        o_cls = C_STORE; o_aluctrl = ALUOP_W'(ALUOp_ADDU); o_alusrc = 1'b1; o_extop = 1'b1; o_byteen = 1'b1;
      end
      OP_SW:  begin o_cls = C_STORE; o_aluctrl = ALUOP_W'(ALUOp_ADDU); o_alusrc = 1'b1; o_extop = 1'b1; end
      OP_BEQ: begin o_cls = C_BEQ; o_aluctrl = ALUOP_W'(ALUOp_SUBU); end
      OP_BNE: begin o_cls = C_BNE; o_aluctrl = ALUOP_W'(ALUOp_SUBU); end
      OP_J:    o_cls = C_J;
      OP_JAL:  o_cls = C_JAL;
      default: o_cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with retired-instruction counter.
// Optional MC_CTRL_EXC_EN adds an EXC state and exc_illegal output for unsupported encodings.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         PC_sel,
  output logic [1:0]         RegDst,
  output logic               ALUSrc,
  output logic               ExtOp,
  output logic [ALUOP_W-1:0] ALUCtrl,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               ByteEn,
  output logic               RegWrite,
  output logic [1:0]         DatatoReg,
`ifdef MC_CTRL_EXC_EN
  output logic               exc_illegal,
`endif
  output logic [CNT_W-1:0]   retired,
  output logic [2:0]         state_o
);

  state_t             r_state;
  cls_t               r_cls;
  logic [ALUOP_W-1:0] r_aluctrl;
  logic               r_alusrc;
  logic               r_extop;
  logic               r_byteen;
  logic [CNT_W-1:0]   r_retired;

  cls_t               w_cls;
  logic [ALUOP_W-1:0] w_aluctrl;
  logic               w_alusrc;
  logic               w_extop;
  logic               w_byteen;
  logic [CNT_W-1:0]   w_retired_inc;

  mc_ctrl_dec #(.ALUOP_W(ALUOP_W)) u_dec (
    .i_opcode  (opcode),
    .i_func    (func),
    .o_cls     (w_cls),
    .o_aluctrl (w_aluctrl),
    .o_alusrc  (w_alusrc),
    .o_extop   (w_extop),
    .o_byteen  (w_byteen)
  );

  assign w_retired_inc = r_retired + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_FETCH;
      r_cls     <= C_ILL;
      r_aluctrl <= '0;
      r_alusrc  <= 1'b0;
      r_extop   <= 1'b0;
      r_byteen  <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_cls     <= w_cls;
          r_aluctrl <= w_aluctrl;
          r_alusrc  <= w_alusrc;
          r_extop   <= w_extop;
          r_byteen  <= w_byteen;
          case (w_cls)
            C_J, C_JAL, C_JR: begin
              r_state   <= S_FETCH;
              r_retired <= w_retired_inc;
            end
`ifdef MC_CTRL_EXC_EN
            C_ILL:   r_state <= S_EXC;
`else
            C_ILL:   r_state <= S_FETCH;
`endif
            default: r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          if (is_mem_cls(r_cls)) begin
            r_state <= S_MEM;
          end else if ((r_cls == C_BEQ) || (r_cls == C_BNE)) begin
            r_state   <= S_FETCH;
            r_retired <= w_retired_inc;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (r_cls == C_LOAD) begin
              r_state <= S_WB;
            end else begin
              r_state   <= S_FETCH;
              r_retired <= w_retired_inc;
            end
          end
        end
        S_WB: begin
          r_state   <= S_FETCH;
          r_retired <= w_retired_inc;
        end
`ifdef MC_CTRL_EXC_EN
        S_EXC:   r_state <= S_FETCH;
`endif
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Controls are a function of state and latched class, forced low while reset is held.
  always_comb begin
    imem_req  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PC_sel    = PCSEL_PC4;
    RegDst    = RD_RT;
    ALUSrc    = 1'b0;
    ExtOp     = 1'b0;
    ALUCtrl   = '0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ByteEn    = 1'b0;
    RegWrite  = 1'b0;
    DatatoReg = WD_ALU;
`ifdef MC_CTRL_EXC_EN
    exc_illegal = 1'b0;
`endif
    if (rstn) begin
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          IRWrite  = imem_ready;
          PCWrite  = imem_ready;
        end
        S_DECODE: begin
          case (w_cls)
            C_J: begin
              PCWrite = 1'b1;
              PC_sel  = PCSEL_JMP;
            end
            C_JAL: begin
              PCWrite   = 1'b1;
              PC_sel    = PCSEL_JMP;
              RegWrite  = 1'b1;
              RegDst    = RD_RA;
              DatatoReg = WD_PC4;
            end
            C_JR: begin
              PCWrite = 1'b1;
              PC_sel  = PCSEL_RS;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          ALUCtrl = r_aluctrl;
          ALUSrc  = r_alusrc;
          ExtOp   = r_extop;
          if (r_cls == C_BEQ) begin
            PCWrite = zero;
            PC_sel  = PCSEL_BR;
          end else if (r_cls == C_BNE) begin
            PCWrite = !zero;
            PC_sel  = PCSEL_BR;
          end
        end
        S_MEM: begin
          ALUCtrl  = r_aluctrl;
          ALUSrc   = r_alusrc;
          ExtOp    = r_extop;
          MemRead  = (r_cls == C_LOAD);
          MemWrite = (r_cls == C_STORE);
          ByteEn   = r_byteen;
        end
        S_WB: begin
          RegWrite  = 1'b1;
          RegDst    = (r_cls == C_RALU) ? RD_RD : RD_RT;
          DatatoReg = (r_cls == C_LOAD) ? WD_MEM : WD_ALU;
        end
`ifdef MC_CTRL_EXC_EN
        S_EXC: begin
          exc_illegal = 1'b1;
          PCWrite     = 1'b1;
          PC_sel      = PCSEL_RS;
        end
`endif
        default: ;
      endcase
    end
  end

  assign retired = r_retired;
  assign state_o = r_state;

endmodule
